// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes received commands, runs register-bank write/read
// handshakes with a timeout, and hands a status/command/data response to the transmitter.
module cmd_sequencer #(
    parameter int unsigned MSG_LENGTH     = 48,
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned COMMAND_WIDTH  = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     packet_received,
    input  logic [COMMAND_WIDTH-1:0] command,
    input  logic [DATA_LENGTH-1:0]   rx_data,
    input  logic                     write_register_ack,
    input  logic                     read_register_ack,
    input  logic [DATA_LENGTH-1:0]   reg_data,
    input  logic                     data_sent,
    output logic                     write_register,
    output logic                     read_register,
    output logic [DATA_LENGTH-1:0]   reg_wdata,
    output logic                     send_data,
    output logic [MSG_LENGTH-1:0]    tx_data,
    output logic                     busy,
    output logic [7:0]               drop_count
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE_REQ = 2'd1;
    localparam logic [1:0] READ_REQ  = 2'd2;
    localparam logic [1:0] RESP_SEND = 2'd3;

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_UNKNOWN = 3'b001;
    localparam logic [2:0] ST_TIMEOUT = 3'b010;

    localparam logic [COMMAND_WIDTH-1:0] CMD_WRITE = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] CMD_READ  = COMMAND_WIDTH'(2);
    localparam logic [COMMAND_WIDTH-1:0] CMD_ECHO  = COMMAND_WIDTH'(3);

    // Last wait cycle: the request stays up for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
    logic [DATA_LENGTH-1:0]   wdata_d;
    logic [MSG_LENGTH-1:0]    tx_d;
    logic [7:0]               drop_d;

    function automatic logic [MSG_LENGTH-1:0] pack(
        input logic [2:0]               st,
        input logic [COMMAND_WIDTH-1:0] c,
        input logic [DATA_LENGTH-1:0]   d
    );
        return MSG_LENGTH'({st, c, 8'h00, d});
    endfunction

    // Next-state, response formatting and drop accounting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        wdata_d = reg_wdata;
        tx_d    = tx_data;
        drop_d  = drop_count;

        unique case (state_q)
            IDLE: begin
                if (packet_received) begin
                    cmd_d   = command;
                    wdata_d = rx_data;
                    cnt_d   = '0;
                    if (command == CMD_WRITE) begin
                        state_d = WRITE_REQ;
                    end else if (command == CMD_READ) begin
                        state_d = READ_REQ;
                    end else if (command == CMD_ECHO) begin
                        state_d = RESP_SEND;
                        tx_d    = pack(ST_OK, command, rx_data);
                    end else begin
                        state_d = RESP_SEND;
                        tx_d    = pack(ST_UNKNOWN, command, '0);
                    end
                end
            end
            WRITE_REQ: begin
                if (write_register_ack) begin
                    state_d = RESP_SEND;
                    tx_d    = pack(ST_OK, cmd_q, '0);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP_SEND;
                    tx_d    = pack(ST_TIMEOUT, cmd_q, '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ_REQ: begin
                if (read_register_ack) begin
                    state_d = RESP_SEND;
                    tx_d    = pack(ST_OK, cmd_q, reg_data);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP_SEND;
                    tx_d    = pack(ST_TIMEOUT, cmd_q, '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP_SEND: begin
                if (data_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (packet_received && (state_q != IDLE) && (drop_count != 8'hFF)) begin
            drop_d = drop_count + 8'd1;
        end
    end

    // State and registered outputs; requests follow the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cmd_q          <= '0;
            reg_wdata      <= '0;
            tx_data        <= '0;
            drop_count     <= '0;
            write_register <= 1'b0;
            read_register  <= 1'b0;
            send_data      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            reg_wdata      <= wdata_d;
            tx_data        <= tx_d;
            drop_count     <= drop_d;
            write_register <= (state_d == WRITE_REQ);
            read_register  <= (state_d == READ_REQ);
            send_data      <= (state_d == RESP_SEND);
            busy           <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: directed and randomized transactions
// compared against a transaction-level model of responses, request lengths and drops.
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        packet_received;
    logic [4:0]  command;
    logic [31:0] rx_data;
    logic        write_register_ack;
    logic        read_register_ack;
    logic [31:0] reg_data;
    logic        data_sent;
    logic        write_register;
    logic        read_register;
    logic [31:0] reg_wdata;
    logic        send_data;
    logic [47:0] tx_data;
    logic        busy;
    logic [7:0]  drop_count;

    int passed = 0;
    int total  = 0;
    int mdrop  = 0;

    cmd_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .packet_received    (packet_received),
        .command            (command),
        .rx_data            (rx_data),
        .write_register_ack (write_register_ack),
        .read_register_ack  (read_register_ack),
        .reg_data           (reg_data),
        .data_sent          (data_sent),
        .write_register     (write_register),
        .read_register      (read_register),
        .reg_wdata          (reg_wdata),
        .send_data          (send_data),
        .tx_data            (tx_data),
        .busy               (busy),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Response packet: status in bits 47:45, command in 44:40, data in 31:0
    function automatic logic [63:0] exp_pkt(input int st, input int c, input logic [31:0] d);
        return 64'(st) * 64'h2000_0000_0000 + 64'(c) * 64'h0100_0000_0000 + 64'(d);
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic clear_inputs();
        packet_received    = 1'b0;
        write_register_ack = 1'b0;
        read_register_ack  = 1'b0;
        data_sent          = 1'b0;
    endtask

    // One command from IDLE through the response handshake; ack_after = 0 means never ack.
    task automatic run_txn(input logic [4:0] c, input logic [31:0] d, input int ack_after,
                           input logic [31:0] rdata, input int n_drops, input int resp_wait,
                           input bit drop_on_sent);
        int   drops_left = n_drops;
        int   req_cycles = 0;
        int   w = 0;
        int   exp_st;
        int   exp_cycles;
        logic [31:0] exp_d;
        logic [47:0] first_tx;
        bit   is_reg = (c == 5'h01) || (c == 5'h02);
        bit   acked  = (ack_after >= 1) && (ack_after <= 255);

        if (c == 5'h01)      begin exp_st = acked ? 0 : 2; exp_d = 32'h0; end
        else if (c == 5'h02) begin exp_st = acked ? 0 : 2; exp_d = acked ? rdata : 32'h0; end
        else if (c == 5'h03) begin exp_st = 0; exp_d = d; end
        else                 begin exp_st = 1; exp_d = 32'h0; end
        exp_cycles = acked ? ack_after : 255;

        @(negedge clk);
        packet_received = 1'b1;
        command         = c;
        rx_data         = d;
        @(negedge clk);
        clear_inputs();
        rx_data = $urandom;
        chk("busy_after_cmd", 64'(busy), 64'd1);

        if (is_reg) begin
            if (c == 5'h01) begin
                chk("wdata", 64'(reg_wdata), 64'(d));
                chk("no_read_on_write", 64'(read_register), 64'd0);
            end else begin
                chk("no_write_on_read", 64'(write_register), 64'd0);
            end
            while (((c == 5'h01) ? write_register : read_register) && req_cycles < 400) begin
                req_cycles++;
                if (c == 5'h01) begin
                    write_register_ack = (req_cycles == ack_after);
                    read_register_ack  = 1'($urandom_range(0, 1));
                end else begin
                    read_register_ack  = (req_cycles == ack_after);
                    write_register_ack = 1'($urandom_range(0, 1));
                end
                reg_data  = (req_cycles == ack_after) ? rdata : $urandom;
                data_sent = 1'($urandom_range(0, 1));
                packet_received = (drops_left > 0);
                command = 5'($urandom);
                if (drops_left > 0) begin
                    drops_left--;
                    mdrop = sat_inc(mdrop);
                end
                @(negedge clk);
            end
            clear_inputs();
            reg_data = $urandom;
            chk("req_cycles", 64'(req_cycles), 64'(exp_cycles));
        end else begin
            chk("no_write_req", 64'(write_register), 64'd0);
            chk("no_read_req", 64'(read_register), 64'd0);
        end

        chk("send_data", 64'(send_data), 64'd1);
        chk("tx_data", 64'(tx_data), exp_pkt(exp_st, int'(c), exp_d));
        first_tx = tx_data;

        while ((drops_left > 0 || w < resp_wait) && w < 1000) begin
            packet_received = (drops_left > 0);
            if (drops_left > 0) begin
                drops_left--;
                mdrop = sat_inc(mdrop);
            end
            @(negedge clk);
            w++;
        end
        clear_inputs();
        chk("send_held", 64'(send_data), 64'd1);
        chk("tx_stable", 64'(tx_data), 64'(first_tx));

        data_sent       = 1'b1;
        packet_received = drop_on_sent;
        if (drop_on_sent) mdrop = sat_inc(mdrop);
        @(negedge clk);
        clear_inputs();
        chk("send_after_sent", 64'(send_data), 64'd0);
        chk("busy_after_sent", 64'(busy), 64'd0);
        chk("drop_count", 64'(drop_count), 64'(mdrop));
    endtask

    initial begin
        int c_sel;
        logic [4:0] rc;

        clear_inputs();
        command  = '0;
        rx_data  = '0;
        reg_data = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_send", 64'(send_data), 64'd0);
        chk("rst_write", 64'(write_register), 64'd0);
        chk("rst_read", 64'(read_register), 64'd0);
        chk("rst_tx", 64'(tx_data), 64'd0);
        chk("rst_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;

        // Directed scenarios
        run_txn(5'h01, 32'hDEADBEEF, 3, 32'h0, 0, 1, 1'b0);
        chk("write_pkt_const", 64'(tx_data), 64'h01_00_00000000);
        run_txn(5'h02, 32'h0, 5, 32'h12345678, 0, 0, 1'b0);
        chk("read_pkt_const", 64'(tx_data), 64'h02_00_12345678);
        run_txn(5'h02, 32'h0, 0, 32'h0, 0, 0, 1'b0);
        chk("timeout_pkt_const", 64'(tx_data), 64'h42_00_00000000);
        run_txn(5'h01, 32'h1, 255, 32'h0, 0, 0, 1'b0);
        run_txn(5'h1F, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 1'b0);
        chk("unknown_pkt_const", 64'(tx_data), 64'h3F_00_00000000);
        run_txn(5'h03, 32'hA5A5A5A5, 0, 32'h0, 0, 2, 1'b0);
        chk("echo_pkt_const", 64'(tx_data), 64'h03_00_A5A5A5A5);

        // Drop counting and saturation
        run_txn(5'h01, 32'h0BAD_F00D, 4, 32'h0, 2, 0, 1'b0);
        chk("drop_two", 64'(drop_count), 64'd2);
        run_txn(5'h03, 32'h5555_AAAA, 0, 32'h0, 300, 0, 1'b1);
        chk("drop_sat", 64'(drop_count), 64'd255);

        // Reset in the middle of a write aborts it without a response
        @(negedge clk);
        packet_received = 1'b1;
        command         = 5'h01;
        rx_data         = 32'hCAFE_0001;
        @(negedge clk);
        clear_inputs();
        chk("mid_write_req", 64'(write_register), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdrop = 0;
        chk("abort_write", 64'(write_register), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_send", 64'(send_data), 64'd0);
        chk("abort_drop", 64'(drop_count), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_send", 64'(send_data), 64'd0);
        run_txn(5'h02, 32'h0, 2, 32'h7777_1234, 0, 0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            c_sel = $urandom_range(0, 3);
            rc    = (c_sel == 0) ? 5'h01 : (c_sel == 1) ? 5'h02 : (c_sel == 2) ? 5'h03 : 5'($urandom);
            run_txn(rc, $urandom, $urandom_range(0, 6), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

endmodule
